// File: rtl/split_serializer.sv
// split_serializer
//   Registered word splitter. Accepts a CHUNKS*CHUNK_W-bit word on an
//   in_valid/in_ready handshake and emits it as CHUNKS consecutive CHUNK_W-bit
//   slices on an out_valid/out_ready handshake, flagging the final slice.
//
// Build option:
//   SPLIT_MSB_FIRST_EN  defined   -> most significant slice first
//                       undefined -> least significant slice first (default)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input word offered
//   in_ready   out  block can take a word this cycle
//   in_data    in   CHUNKS*CHUNK_W word to split
//   out_valid  out  out_data holds a valid slice
//   out_ready  in   consumer takes the slice this cycle
//   out_data   out  CHUNK_W current slice
//   out_idx    out  IDX_W index of the current slice (0..CHUNKS-1)
//   out_last   out  high with the final slice of a word
//
// state | meaning
// ------+----------------------------------
// IDLE  | no word held, ready for input
// BUSY  | word held, slices pending
module split_serializer #(
  parameter int CHUNK_W = 6,
  parameter int CHUNKS  = 2,
  parameter int IDX_W   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHUNKS*CHUNK_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHUNK_W-1:0]        out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHUNKS - 1);

  state_t                    state;
  logic [CHUNKS*CHUNK_W-1:0] hold;
  logic [IDX_W-1:0]          idx;
  logic                      busy;
  logic                      at_last;
  logic [CHUNK_W-1:0]        slice;

  assign busy    = (state == BUSY);
  assign at_last = (idx == IDX_LAST);

  // Explicit compare-per-slice mux keeps the select bounded to real slices,
  // so an idx value beyond CHUNKS-1 could never reach outside hold.
  always_comb begin
    slice = '0;
    for (int k = 0; k < CHUNKS; k++) begin
      if (idx == IDX_W'(k)) begin
`ifdef SPLIT_MSB_FIRST_EN
        slice = hold[(CHUNKS-1-k)*CHUNK_W +: CHUNK_W];
`else
        slice = hold[k*CHUNK_W +: CHUNK_W];
`endif
      end
    end
  end

  // Outputs are decoded purely from registered state; in_data never reaches
  // them combinationally. Masking with busy keeps them at zero while idle.
  assign out_valid = busy;
  assign out_data  = busy ? slice : '0;
  assign out_idx   = idx;
  assign out_last  = busy && at_last;

  // Accepting on the cycle the last slice leaves gives back-to-back words
  // with no idle cycle between them.
  assign in_ready = !busy || (at_last && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hold  <= in_data;
            idx   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (out_ready) begin
            if (!at_last) begin
              idx <= idx + IDX_W'(1);
            end else begin
              idx <= '0;
              if (in_valid) begin
                hold <= in_data;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_split_serializer.sv
module tb_split_serializer;

  logic        clk;
  logic        rst_n;

  // default configuration: CHUNK_W=6, CHUNKS=2, IDX_W=1
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [11:0] in_data;
  logic [5:0]  out_data;
  logic [0:0]  out_idx;

  // three-slice configuration: CHUNK_W=4, CHUNKS=3, IDX_W=2
  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
  logic [11:0] in_data2;
  logic [3:0]  out_data2;
  logic [1:0]  out_idx2;

  int checks = 0;
  int errors = 0;

  split_serializer #(.CHUNK_W(6), .CHUNKS(2), .IDX_W(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  split_serializer #(.CHUNK_W(4), .CHUNKS(3), .IDX_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_idx(out_idx2), .out_last(out_last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [5:0] d,
                         input logic i, input logic l, input logic r);
    chk({tag, ".valid"},    32'(out_valid), 32'(v));
    chk({tag, ".data"},     32'(out_data),  32'(d));
    chk({tag, ".idx"},      32'(out_idx),   32'(i));
    chk({tag, ".last"},     32'(out_last),  32'(l));
    chk({tag, ".in_ready"}, 32'(in_ready),  32'(r));
  endtask

  // Expected nibbles of each word, listed least significant first.
  logic [3:0] nib [4][3];
  logic [11:0] words3 [4];
  int last_count;

  initial begin
    words3[0] = 12'h5A3; nib[0][0] = 4'h3; nib[0][1] = 4'hA; nib[0][2] = 4'h5;
    words3[1] = 12'h123; nib[1][0] = 4'h3; nib[1][1] = 4'h2; nib[1][2] = 4'h1;
    words3[2] = 12'hFED; nib[2][0] = 4'hD; nib[2][1] = 4'hE; nib[2][2] = 4'hF;
    words3[3] = 12'h0F0; nib[3][0] = 4'h0; nib[3][1] = 4'hF; nib[3][2] = 4'h0;

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    #12;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data",  32'(out_data),  32'd0);
    chk("rst.idx",   32'(out_idx),   32'd0);
    chk("rst.last",  32'(out_last),  32'd0);
    chk("rst.valid3", 32'(out_valid2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // Test 1: single word, LSB first
    in_valid = 1'b1; in_data = 12'hABC;
    step();
    in_valid = 1'b0; in_data = 12'hFFF;
    #1;
    chk_out("t1.b0", 1'b1, 6'h3C, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("t1.b1", 1'b1, 6'h2A, 1'b1, 1'b1, 1'b1);
    step();
    chk("t1.done.valid", 32'(out_valid), 32'd0);
    chk("t1.done.in_ready", 32'(in_ready), 32'd1);

    // Test 2: back-to-back words
    in_valid = 1'b1; in_data = 12'hABC;
    step();
    in_data = 12'h041;
    #1;
    chk_out("t2.w0b0", 1'b1, 6'h3C, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("t2.w0b1", 1'b1, 6'h2A, 1'b1, 1'b1, 1'b1);
    step();
    in_valid = 1'b0; in_data = 12'hFFF;
    #1;
    chk_out("t2.w1b0", 1'b1, 6'h01, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("t2.w1b1", 1'b1, 6'h01, 1'b1, 1'b1, 1'b1);
    step();
    chk("t2.done.valid", 32'(out_valid), 32'd0);

    // Test 3: back-pressure during slice 0
    in_valid = 1'b1; in_data = 12'hABC;
    step();
    in_valid = 1'b1; in_data = 12'h555;  // offered but must be refused
    for (int c = 0; c < 3; c++) begin
      out_ready = 1'b0;
      #1;
      chk_out($sformatf("t3.stall%0d", c), 1'b1, 6'h3C, 1'b0, 1'b0, 1'b0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk_out("t3.b0", 1'b1, 6'h3C, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("t3.b1", 1'b1, 6'h2A, 1'b1, 1'b1, 1'b1);
    step();
    chk("t3.done.valid", 32'(out_valid), 32'd0);

    // Test 4: reset mid-word
    in_valid = 1'b1; in_data = 12'hABC;
    step();
    in_valid = 1'b0;
    #1;
    chk_out("t4.b0", 1'b1, 6'h3C, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("t4.rst.valid", 32'(out_valid), 32'd0);
    chk("t4.rst.idx",   32'(out_idx),   32'd0);
    chk("t4.rst.data",  32'(out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("t4.quiet%0d", c), 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1; in_data = 12'h041;
    step();
    in_valid = 1'b0;
    #1;
    chk_out("t4.w1b0", 1'b1, 6'h01, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("t4.w1b1", 1'b1, 6'h01, 1'b1, 1'b1, 1'b1);
    step();
    chk("t4.done.valid", 32'(out_valid), 32'd0);

    // Tests 5/6: three slices of four bits, four words back to back
    last_count = 0;
    in_valid2 = 1'b1; in_data2 = words3[0];
    step();
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 3; k++) begin
`ifdef SPLIT_MSB_FIRST_EN
        chk($sformatf("t5.w%0db%0d.data", w, k), 32'(out_data2), 32'(nib[w][2-k]));
`else
        chk($sformatf("t5.w%0db%0d.data", w, k), 32'(out_data2), 32'(nib[w][k]));
`endif
        chk($sformatf("t5.w%0db%0d.valid", w, k), 32'(out_valid2), 32'd1);
        chk($sformatf("t5.w%0db%0d.idx", w, k), 32'(out_idx2), 32'(k));
        chk($sformatf("t5.w%0db%0d.last", w, k), 32'(out_last2), 32'(k == 2));
        chk($sformatf("t5.w%0db%0d.in_ready", w, k), 32'(in_ready2), 32'(k == 2));
        if (out_last2) last_count++;
        if (k == 2) begin
          if (w < 3) in_data2 = words3[w+1];
          else in_valid2 = 1'b0;
        end
        step();
      end
    end
    chk("t6.last_count", 32'(last_count), 32'd4);
    chk("t6.done.valid", 32'(out_valid2), 32'd0);
    chk("t6.done.idx",   32'(out_idx2),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
